// File: rtl/secded_pkg.sv
// secded_pkg
//   Shared types and elaboration-time helpers for the SECDED channel.
//   secded_pw : number of Hamming parity bits for a given data width
//   is_pow2   : true when a codeword position holds a Hamming parity bit
//   data_pos  : codeword position of data bit i (data fills non-parity
//               positions in ascending order, starting at position 3)
package secded_pkg;

  typedef enum logic [1:0] {
    CLS_CLEAN  = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_DOUBLE = 2'd2
  } secded_cls_e;

  function automatic bit is_pow2(input int unsigned pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Smallest p with 2^p >= data_w + p + 1.
  function automatic int unsigned secded_pw(input int unsigned data_w);
    int unsigned pw;
    pw = 0;
    for (int unsigned p = 1; p <= 8; p++) begin
      if ((pw == 0) && ((32'd1 << p) >= (data_w + p + 1))) pw = p;
    end
    return pw;
  endfunction

  // Position 0 and powers of two are parity; every other position, in
  // ascending order, carries the next data bit.
  function automatic int unsigned data_pos(input int unsigned i,
                                           input int unsigned data_w);
    int unsigned cnt;
    int unsigned res;
    cnt = 0;
    res = 0;
    for (int unsigned pos = 1; pos < 128; pos++) begin
      if (!is_pow2(pos)) begin
        if ((cnt == i) && (cnt < data_w)) res = pos;
        cnt++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// secded_syndrome
//   Combinational syndrome / overall-parity check of a received codeword.
//   cw_i  : received codeword, CW_W bits (position 0 = overall parity)
//   syn_o : XOR of the indices of all set bits in positions 1..CW_W-1
//   ov_o  : XOR of every codeword bit
module secded_syndrome #(
  parameter int unsigned CW_W = 13,
  parameter int unsigned P_W  = 4
) (
  input  logic [CW_W-1:0] cw_i,
  output logic [P_W-1:0]  syn_o,
  output logic            ov_o
);

  always_comb begin
    syn_o = '0;
    for (int unsigned pos = 1; pos < CW_W; pos++) begin
      if (cw_i[P_W'(pos)]) syn_o = syn_o ^ P_W'(pos);
    end
  end

  assign ov_o = ^cw_i;

endmodule

// File: rtl/secded_channel.sv
// secded_channel
//   Three-stage pipelined SECDED Hamming channel with per-word error
//   injection, valid/ready streaming and saturating error counters.
//   S1: encode + XOR inj_mask, S2: syndrome/overall parity, S3: correct.
//   Ports:
//     clk, rst_n                       clock, synchronous active-low reset
//     in_valid/in_ready/in_data        input stream (in_ready is combinational
//                                      from out_ready through the stall chain)
//     inj_mask                         CW_W-bit flip mask, taken with the word
//     out_valid/out_ready              output handshake
//     out_data/out_single/out_double/  corrected data, flags and syndrome
//     out_syndrome
//     cnt_clear                        clears both counters (wins over +1)
//     corr_count/uncorr_count          saturating counts of delivered
//                                      single / double words
module secded_channel
  import secded_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned P_W    = secded_pw(DATA_W),
  localparam int unsigned CW_W   = DATA_W + P_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CW_W-1:0]   inj_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_single,
  output logic              out_double,
  output logic [P_W-1:0]    out_syndrome,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  corr_count,
  output logic [CNT_W-1:0]  uncorr_count
);

  logic              v1_q, v2_q, v3_q;
  logic              adv1, adv2, adv3;
  logic              out_hs;

  logic [CW_W-1:0]   enc_cw;
  logic [CW_W-1:0]   cw1_q;
  logic [DATA_W-1:0] raw1;
  logic [P_W-1:0]    syn1;
  logic              ov1;

  logic [DATA_W-1:0] raw2_q;
  logic [P_W-1:0]    syn2_q;
  logic              ov2_q;

  secded_cls_e       cls;
  logic [DATA_W-1:0] dec_data;

  logic [DATA_W-1:0] data_q;
  logic              single_q, double_q;
  logic [P_W-1:0]    syn3_q;

  logic [CNT_W-1:0]  corr_q, corr_d;
  logic [CNT_W-1:0]  uncorr_q, uncorr_d;

  // Stall chain: a stage moves when empty or when its successor moves.
  assign adv3     = !v3_q || out_ready;
  assign adv2     = !v2_q || adv3;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;
  assign out_hs   = v3_q && out_ready;

  // ---------------- S1: encode and inject ----------------
  always_comb begin
    logic [CW_W-1:0] cw;
    logic            par;
    cw  = '0;
    par = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      cw[P_W'(data_pos(i, DATA_W))] = in_data[i];
    end
    for (int unsigned k = 0; k < P_W; k++) begin
      par = 1'b0;
      for (int unsigned pos = 3; pos < CW_W; pos++) begin
        if (!is_pow2(pos) && (((pos >> k) & 1) == 1)) par = par ^ cw[P_W'(pos)];
      end
      cw[P_W'(1 << k)] = par;
    end
    cw[0]  = ^cw[CW_W-1:1];
    enc_cw = cw;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    v1_q <= 1'b0;
    else if (adv1) v1_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv1) cw1_q <= enc_cw ^ inj_mask;
  end

  // ---------------- S2: syndrome ----------------
  secded_syndrome #(
    .CW_W (CW_W),
    .P_W  (P_W)
  ) u_syndrome (
    .cw_i  (cw1_q),
    .syn_o (syn1),
    .ov_o  (ov1)
  );

  // Parity positions are fully consumed by the syndrome, so only the data
  // positions of the received codeword travel on into S2.
  always_comb begin
    raw1 = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      raw1[i] = cw1_q[P_W'(data_pos(i, DATA_W))];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    v2_q <= 1'b0;
    else if (adv2) v2_q <= v1_q;
  end

  always_ff @(posedge clk) begin
    if (adv2) begin
      raw2_q <= raw1;
      syn2_q <= syn1;
      ov2_q  <= ov1;
    end
  end

  // ---------------- S3: classify and correct ----------------
  // Flipping codeword position s then extracting is equivalent to flipping
  // the data bit whose position equals s; s=0 or a parity position leaves
  // the data untouched.
  always_comb begin
    cls = CLS_DOUBLE;
    if (syn2_q == '0)                         cls = ov2_q ? CLS_SINGLE : CLS_CLEAN;
    else if (ov2_q && (32'(syn2_q) < CW_W))   cls = CLS_SINGLE;

    dec_data = raw2_q;
    if (cls == CLS_SINGLE) begin
      for (int unsigned i = 0; i < DATA_W; i++) begin
        if (syn2_q == P_W'(data_pos(i, DATA_W))) dec_data[i] = ~raw2_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v3_q     <= 1'b0;
      data_q   <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      syn3_q   <= '0;
    end else if (adv3) begin
      v3_q <= v2_q;
      if (v2_q) begin
        data_q   <= dec_data;
        single_q <= (cls == CLS_SINGLE);
        double_q <= (cls == CLS_DOUBLE);
        syn3_q   <= syn2_q;
      end
    end
  end

  assign out_valid    = v3_q;
  assign out_data     = data_q;
  assign out_single   = single_q;
  assign out_double   = double_q;
  assign out_syndrome = syn3_q;

  // ---------------- error counters ----------------
  always_comb begin
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    if (cnt_clear) begin
      corr_d   = '0;
      uncorr_d = '0;
    end else if (out_hs) begin
      if (single_q && (corr_q != '1))   corr_d   = corr_q + CNT_W'(1);
      if (double_q && (uncorr_q != '1)) uncorr_d = uncorr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else begin
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
    end
  end

  assign corr_count   = corr_q;
  assign uncorr_count = uncorr_q;

endmodule

// File: tb/tb_secded_channel.sv
// tb_secded_channel
//   Directed bench for secded_channel: an 8-bit instance with 2-bit counters
//   (handshake, latency, backpressure, counter edges, reset) and a 64-bit
//   instance (single-bit sweep over all 72 positions). Expected results come
//   from an error-pattern model: a clean codeword has zero syndrome, so the
//   received syndrome is the XOR of the flipped positions and the received
//   data is the input XORed with the flips that land on data positions.
module tb_secded_channel;

  typedef struct {
    logic [63:0] data;
    logic        single;
    logic        dbl;
    logic [6:0]  syn;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 8-bit instance
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [7:0]  in_data_a, out_data_a;
  logic [12:0] inj_mask_a;
  logic        out_single_a, out_double_a, cnt_clear_a;
  logic [3:0]  out_syndrome_a;
  logic [1:0]  corr_count_a, uncorr_count_a;

  // 64-bit instance
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [63:0] in_data_b, out_data_b;
  logic [71:0] inj_mask_b;
  logic        out_single_b, out_double_b, cnt_clear_b;
  logic [6:0]  out_syndrome_b;
  logic [15:0] corr_count_b, uncorr_count_b;

  secded_channel #(.DATA_W(8), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .inj_mask(inj_mask_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_single(out_single_a), .out_double(out_double_a),
    .out_syndrome(out_syndrome_a),
    .cnt_clear(cnt_clear_a), .corr_count(corr_count_a),
    .uncorr_count(uncorr_count_a)
  );

  secded_channel #(.DATA_W(64), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .inj_mask(inj_mask_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_single(out_single_b), .out_double(out_double_b),
    .out_syndrome(out_syndrome_b),
    .cnt_clear(cnt_clear_b), .corr_count(corr_count_b),
    .uncorr_count(uncorr_count_b)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  int   corr_m = 0;
  int   uncorr_m = 0;
  logic acc_a = 1'b0;
  logic acc_b = 1'b0;
  logic stall_a = 1'b0;
  exp_t held_a;

  function automatic exp_t model(input logic [63:0] d, input logic [71:0] m,
                                 input int unsigned dw);
    exp_t        e;
    int unsigned pw, cw, s, j;
    logic        ov;
    logic [71:0] err;
    pw = (dw == 8) ? 4 : (dw == 16) ? 5 : (dw == 32) ? 6 : 7;
    cw = dw + pw + 1;
    s  = 0;
    ov = 1'b0;
    j  = 0;
    for (int unsigned p = 0; p < cw; p++) begin
      if (m[7'(p)]) begin
        ov = ~ov;
        s  = s ^ p;
      end
    end
    e.single = 1'b0;
    e.dbl    = 1'b0;
    if ((s != 0) || ov) begin
      if (ov && (s < cw)) e.single = 1'b1;
      else                e.dbl    = 1'b1;
    end
    err = m;
    if (e.single && (s != 0)) err[7'(s)] = ~err[7'(s)];
    e.data = d;
    for (int unsigned p = 1; p < cw; p++) begin
      if ((p & (p - 1)) != 0) begin
        e.data[6'(j)] = e.data[6'(j)] ^ err[7'(p)];
        j++;
      end
    end
    e.syn = 7'(s);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mon_a();
    exp_t e;
    logic hs, got;
    got = 1'b0;
    if (rst_n === 1'b1) begin
      chk("corr_count", corr_count_a, corr_m);
      chk("uncorr_count", uncorr_count_a, uncorr_m);
      if (stall_a) begin
        chk("hold_valid", out_valid_a, 1'b1);
        chk("hold_data", out_data_a, held_a.data);
        chk("hold_single", out_single_a, held_a.single);
        chk("hold_double", out_double_a, held_a.dbl);
        chk("hold_syndrome", out_syndrome_a, held_a.syn);
      end
    end
    stall_a = (rst_n === 1'b1) && (out_valid_a === 1'b1) && (out_ready_a === 1'b0);
    held_a.data   = 64'(out_data_a);
    held_a.single = out_single_a;
    held_a.dbl    = out_double_a;
    held_a.syn    = 7'(out_syndrome_a);
    hs    = (rst_n === 1'b1) && (out_valid_a === 1'b1) && (out_ready_a === 1'b1);
    acc_a = (rst_n === 1'b1) && (in_valid_a === 1'b1) && (in_ready_a === 1'b1);
    if (hs) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_word", out_valid_a, 1'b0);
      end else begin
        e   = qa.pop_front();
        got = 1'b1;
        chk("a_data", out_data_a, e.data);
        chk("a_single", out_single_a, e.single);
        chk("a_double", out_double_a, e.dbl);
        chk("a_syndrome", out_syndrome_a, e.syn);
      end
    end
    if (rst_n !== 1'b1) begin
      corr_m = 0;
      uncorr_m = 0;
      qa.delete();
    end else if (cnt_clear_a === 1'b1) begin
      corr_m = 0;
      uncorr_m = 0;
    end else if (got) begin
      if (e.single && (corr_m < 3))   corr_m++;
      if (e.dbl    && (uncorr_m < 3)) uncorr_m++;
    end
    if (acc_a) qa.push_back(model(64'(in_data_a), 72'(inj_mask_a), 8));
  endtask

  task automatic mon_b();
    exp_t e;
    logic hs;
    hs    = (rst_n === 1'b1) && (out_valid_b === 1'b1) && (out_ready_b === 1'b1);
    acc_b = (rst_n === 1'b1) && (in_valid_b === 1'b1) && (in_ready_b === 1'b1);
    if (hs) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_word", out_valid_b, 1'b0);
      end else begin
        e = qb.pop_front();
        chk("b_data", out_data_b, e.data);
        chk("b_single", out_single_b, e.single);
        chk("b_double", out_double_b, e.dbl);
        chk("b_syndrome", out_syndrome_b, e.syn);
      end
    end
    if (rst_n !== 1'b1) qb.delete();
    if (acc_b) qb.push_back(model(in_data_b, inj_mask_b, 64));
  endtask

  task automatic tick();
    @(negedge clk);
    mon_a();
    mon_b();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d, input logic [12:0] m);
    int n;
    in_valid_a = 1'b1;
    in_data_a  = d;
    inj_mask_a = m;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc_a && (n < 20));
    in_valid_a = 1'b0;
    chk("send_a_accepted", acc_a, 1'b1);
  endtask

  task automatic drain_a();
    for (int n = 0; (n < 40) && (qa.size() != 0); n++) tick();
    chk("drain_a_outstanding", qa.size(), 0);
  endtask

  task automatic drain_b();
    for (int n = 0; (n < 40) && (qb.size() != 0); n++) tick();
    chk("drain_b_outstanding", qb.size(), 0);
  endtask

  task automatic look_a(input string tag, input logic [7:0] d, input logic s,
                        input logic db, input logic [3:0] syn);
    chk({tag, "_valid"}, out_valid_a, 1'b1);
    chk({tag, "_data"}, out_data_a, d);
    chk({tag, "_single"}, out_single_a, s);
    chk({tag, "_double"}, out_double_a, db);
    chk({tag, "_syndrome"}, out_syndrome_a, syn);
  endtask

  logic [7:0]  bp_data [8];
  logic [12:0] bp_mask [8];
  int          idx;

  initial begin
    rst_n = 1'b0;
    in_valid_a = 1'b0; in_data_a = '0; inj_mask_a = '0;
    out_ready_a = 1'b1; cnt_clear_a = 1'b0;
    in_valid_b = 1'b0; in_data_b = '0; inj_mask_b = '0;
    out_ready_b = 1'b1; cnt_clear_b = 1'b0;
    bp_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    bp_mask = '{13'h0000, 13'h0008, 13'h1000, 13'h0048,
                13'h0001, 13'h0000, 13'h0080, 13'h0112};

    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    // State right after reset.
    chk("rst_in_ready", in_ready_a, 1'b1);
    chk("rst_out_valid", out_valid_a, 1'b0);
    chk("rst_out_data", out_data_a, 8'h00);
    chk("rst_out_single", out_single_a, 1'b0);
    chk("rst_out_double", out_double_a, 1'b0);
    chk("rst_out_syndrome", out_syndrome_a, 4'h0);
    chk("rst_corr", corr_count_a, 2'd0);
    chk("rst_uncorr", uncorr_count_a, 2'd0);
    chk("rst_b_out_valid", out_valid_b, 1'b0);

    // Clean word with three-edge latency.
    in_valid_a = 1'b1; in_data_a = 8'hA5; inj_mask_a = '0;
    tick();
    in_valid_a = 1'b0;
    chk("clean_accepted", acc_a, 1'b1);
    chk("lat_edge1", out_valid_a, 1'b0);
    tick();
    chk("lat_edge2", out_valid_a, 1'b0);
    tick();
    look_a("clean", 8'hA5, 1'b0, 1'b0, 4'd0);
    drain_a();
    chk("clean_corr", corr_count_a, 2'd0);
    chk("clean_uncorr", uncorr_count_a, 2'd0);

    // Single error on data position 5, then on the overall parity bit.
    send_a(8'h3C, 13'h0020);
    tick(); tick();
    look_a("single_p5", 8'h3C, 1'b1, 1'b0, 4'd5);
    drain_a();
    chk("single_p5_corr", corr_count_a, 2'd1);
    send_a(8'h3C, 13'h0001);
    tick(); tick();
    look_a("single_p0", 8'h3C, 1'b1, 1'b0, 4'd0);
    drain_a();
    chk("single_p0_corr", corr_count_a, 2'd2);

    // Double error at positions 3 and 6.
    send_a(8'h00, 13'h0048);
    tick(); tick();
    look_a("double_3_6", 8'h05, 1'b0, 1'b1, 4'd5);
    drain_a();
    chk("double_uncorr", uncorr_count_a, 2'd1);

    // Three flips giving s=13 > CW_W-1 with odd parity: uncorrectable.
    send_a(8'h5A, 13'h0112);
    tick(); tick();
    look_a("s_out_of_range", 8'h5A, 1'b0, 1'b1, 4'd13);
    drain_a();
    chk("oor_uncorr", uncorr_count_a, 2'd2);

    // Backpressure: 8 words streamed, output stalled for cycles 4..7.
    idx = 0;
    for (int c = 0; c < 24; c++) begin
      in_valid_a  = (idx < 8);
      in_data_a   = bp_data[(idx < 8) ? idx : 0];
      inj_mask_a  = bp_mask[(idx < 8) ? idx : 0];
      out_ready_a = !((c >= 4) && (c <= 7));
      #1;
      if ((c >= 4) && (c <= 7)) chk("bp_in_ready_full", in_ready_a, 1'b0);
      tick();
      if (acc_a) idx++;
    end
    in_valid_a  = 1'b0;
    out_ready_a = 1'b1;
    drain_a();
    chk("bp_words_accepted", idx, 8);

    // Saturation of the 2-bit corrected counter.
    cnt_clear_a = 1'b1;
    tick();
    cnt_clear_a = 1'b0;
    chk("clear_corr", corr_count_a, 2'd0);
    chk("clear_uncorr", uncorr_count_a, 2'd0);
    for (int k = 0; k < 5; k++) send_a(8'(8'h40 + k), 13'(13'h0002 << k));
    drain_a();
    chk("sat_corr", corr_count_a, 2'd3);

    // Clear in the same cycle as a counted handshake.
    out_ready_a = 1'b0;
    send_a(8'h77, 13'h0004);
    for (int n = 0; (n < 10) && (out_valid_a !== 1'b1); n++) tick();
    chk("clrhs_wait_valid", out_valid_a, 1'b1);
    chk("clrhs_single_flag", out_single_a, 1'b1);
    cnt_clear_a = 1'b1;
    out_ready_a = 1'b1;
    tick();
    cnt_clear_a = 1'b0;
    chk("clear_wins", corr_count_a, 2'd0);
    chk("clrhs_delivered", qa.size(), 0);
    send_a(8'h99, 13'h0400);
    drain_a();
    chk("count_after_clear", corr_count_a, 2'd1);

    // Reset with two words in flight.
    in_valid_a = 1'b1; in_data_a = 8'h01; inj_mask_a = 13'h0020;
    tick();
    in_data_a = 8'h02; inj_mask_a = 13'h0048;
    tick();
    in_valid_a = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      #1;
      chk("post_rst_no_valid", out_valid_a, 1'b0);
      tick();
    end
    chk("post_rst_corr", corr_count_a, 2'd0);
    chk("post_rst_uncorr", uncorr_count_a, 2'd0);
    chk("post_rst_in_ready", in_ready_a, 1'b1);

    // 64-bit sweep: one flipped bit at every codeword position.
    for (int p = 0; p < 72; p++) begin
      in_valid_b = 1'b1;
      in_data_b  = {$urandom(), $urandom()};
      inj_mask_b = 72'd1 << p;
      tick();
      chk("b_sweep_accepted", acc_b, 1'b1);
    end
    // A few adjacent double flips on the wide instance.
    for (int p = 5; p < 70; p += 16) begin
      in_data_b  = {$urandom(), $urandom()};
      inj_mask_b = 72'd3 << p;
      tick();
      chk("b_double_accepted", acc_b, 1'b1);
    end
    in_valid_b = 1'b0;
    drain_b();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
